// File: rtl/ip_ccm3_prog_if.sv
// ip_ccm3_prog_if
// Pixel-stream and coefficient-port bundle for ip_ccm3_prog.
//   master : drives pixel inputs, sync inputs and coefficient writes/commit
//   slave  : the converter; drives clipped outputs, delayed sync, pending flag
// Parameters:
//   CIW : input channel width (c0 unsigned, c1/c2 carry one extra sign bit)
//   COW : output channel width
`timescale 1ns/1ps

interface ip_ccm3_prog_if #(
  parameter int CIW = 12,
  parameter int COW = 12
);
  logic        [CIW-1:0] i_data_c0;
  logic signed [CIW:0]   i_data_c1_sgn;
  logic signed [CIW:0]   i_data_c2_sgn;
  logic                  i_hstr;
  logic                  i_href;
  logic                  i_hend;
  logic                  i_cfg_wr;
  logic        [3:0]     i_cfg_addr;
  logic signed [15:0]    i_cfg_data;
  logic                  i_cfg_commit;
  logic        [COW-1:0] o_data_0;
  logic        [COW-1:0] o_data_1;
  logic        [COW-1:0] o_data_2;
  logic                  o_hstr;
  logic                  o_href;
  logic                  o_hend;
  logic                  o_cfg_pend;

  modport master (
    output i_data_c0, i_data_c1_sgn, i_data_c2_sgn, i_hstr, i_href, i_hend,
    output i_cfg_wr, i_cfg_addr, i_cfg_data, i_cfg_commit,
    input  o_data_0, o_data_1, o_data_2, o_hstr, o_href, o_hend, o_cfg_pend
  );

  modport slave (
    input  i_data_c0, i_data_c1_sgn, i_data_c2_sgn, i_hstr, i_href, i_hend,
    input  i_cfg_wr, i_cfg_addr, i_cfg_data, i_cfg_commit,
    output o_data_0, o_data_1, o_data_2, o_hstr, o_href, o_hend, o_cfg_pend
  );
endinterface

// File: rtl/ip_ccm3_prog.sv
// ip_ccm3_prog
// Programmable 3x3 colour-matrix converter with S3.12 coefficients, four-stage
// pipeline (normalise / multiply / sum-round-shift / clip) and a shadow/commit
// coefficient port whose transfer to the active set happens only in blanking.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   o_sat_cnt  : clipped-pixel count of the last line (IP_CCM3_SAT_CNT_EN only)
//   bus        : ip_ccm3_prog_if.slave (pixels, sync, coefficient port, outputs)
// Optional feature macro: IP_CCM3_SAT_CNT_EN (per-line clip counter).
`timescale 1ns/1ps

module ip_ccm3_prog #(
  parameter int CIIW      = 8,
  parameter int CIPW      = 4,
  parameter int COIW      = 8,
  parameter int COPW      = 4,
  parameter int CIW       = CIIW + CIPW,
  parameter int COW       = COIW + COPW,
  parameter bit YCBCR_POS = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef IP_CCM3_SAT_CNT_EN
  output logic [15:0]         o_sat_cnt,
`endif
  ip_ccm3_prog_if.slave       bus
);

  localparam int NW = CIW + 2;
  localparam int PW = NW + 16;
  localparam int AW = PW + 2;
  localparam int SH = 12 + CIPW - COPW;
  localparam int RW = AW - SH;

  localparam logic signed [NW-1:0] OFFS = YCBCR_POS ? NW'(2 ** (CIW - 1)) : '0;
  localparam logic signed [AW-1:0] RND  = AW'(2 ** (SH - 1));
  localparam logic signed [RW-1:0] OMAX = RW'(2 ** COW - 1);

  // Defaults reproduce the legacy YCbCr-to-LMS stage, row-major m00..m22.
  localparam logic signed [15:0] DEF_M [9] = '{
    16'sd4096, -16'sd384,  16'sd802,
    16'sd4096, -16'sd181, -16'sd777,
    16'sd4096,  16'sd4192, -16'sd318
  };

  logic signed [15:0]    shadow [9];
  logic signed [15:0]    active [9];
  logic                  pend;
  logic                  apply;

  logic signed [NW-1:0]  n_c   [3];
  logic signed [NW-1:0]  s1_n  [3];
  logic signed [PW-1:0]  s2_p  [9];
  logic signed [AW-1:0]  acc_c [3];
  logic signed [RW-1:0]  res_c [3];
  logic signed [RW-1:0]  s3_r  [3];
  logic        [COW-1:0] clip_c [3];
  logic                  clip_any;
  logic [2:0]            sync_s1, sync_s2, sync_s3;

  // Transfer only while the input is idle so a line never sees mixed sets.
  assign apply          = pend && !bus.i_href && !bus.i_hstr;
  assign bus.o_cfg_pend = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        shadow[i] <= DEF_M[i];
        active[i] <= DEF_M[i];
      end
      pend <= 1'b0;
    end else begin
      if (bus.i_cfg_wr && (bus.i_cfg_addr <= 4'd8))
        shadow[bus.i_cfg_addr] <= bus.i_cfg_data;
      if (apply) begin
        active <= shadow;
        pend   <= 1'b0;
      end else if (bus.i_cfg_commit) begin
        pend <= 1'b1;
      end
    end
  end

  // Normalisation, sum/round/shift and clip are combinational feeders of the
  // S1, S3 and S4 registers respectively.
  always_comb begin
    n_c[0] = $signed({2'b00, bus.i_data_c0});
    n_c[1] = $signed({bus.i_data_c1_sgn[CIW], bus.i_data_c1_sgn}) - OFFS;
    n_c[2] = $signed({bus.i_data_c2_sgn[CIW], bus.i_data_c2_sgn}) - OFFS;
    for (int k = 0; k < 3; k++) begin
      acc_c[k] = AW'(s2_p[3*k]) + AW'(s2_p[3*k+1]) + AW'(s2_p[3*k+2]) + RND;
      res_c[k] = RW'(acc_c[k] >>> SH);
    end
    clip_any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clip_c[k] = s3_r[k][COW-1:0];
      if (s3_r[k] < 0) begin
        clip_c[k] = '0;
        clip_any  = 1'b1;
      end else if (s3_r[k] > OMAX) begin
        clip_c[k] = '1;
        clip_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) s1_n[j] <= '0;
      for (int i = 0; i < 9; i++) s2_p[i] <= '0;
      for (int k = 0; k < 3; k++) s3_r[k] <= '0;
      sync_s1      <= '0;
      sync_s2      <= '0;
      sync_s3      <= '0;
      bus.o_data_0 <= '0;
      bus.o_data_1 <= '0;
      bus.o_data_2 <= '0;
      bus.o_hstr   <= 1'b0;
      bus.o_href   <= 1'b0;
      bus.o_hend   <= 1'b0;
    end else begin
      for (int j = 0; j < 3; j++) s1_n[j] <= n_c[j];
      // Full-width products; the active set is sampled here only.
      for (int i = 0; i < 9; i++) s2_p[i] <= PW'(s1_n[i % 3]) * PW'(active[i]);
      for (int k = 0; k < 3; k++) s3_r[k] <= res_c[k];
      bus.o_data_0 <= clip_c[0];
      bus.o_data_1 <= clip_c[1];
      bus.o_data_2 <= clip_c[2];
      sync_s1 <= {bus.i_hstr, bus.i_href, bus.i_hend};
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
      {bus.o_hstr, bus.o_href, bus.o_hend} <= sync_s3;
    end
  end

`ifdef IP_CCM3_SAT_CNT_EN
  logic [15:0] sat_run;
  logic [15:0] sat_base;
  logic [15:0] sat_next;

  // sync_s3 is the sync of the pixel being clipped into the output this cycle.
  always_comb begin
    sat_base = sync_s3[2] ? 16'd0 : sat_run;
    sat_next = sat_base;
    if (sync_s3[1] && clip_any && (sat_base != 16'hFFFF))
      sat_next = sat_base + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_run   <= '0;
      o_sat_cnt <= '0;
    end else if (sync_s3[0]) begin
      o_sat_cnt <= sat_next;
      sat_run   <= '0;
    end else begin
      sat_run <= sat_next;
    end
  end
`endif

endmodule

// File: tb/tb_ip_ccm3_prog.sv
// tb_ip_ccm3_prog
// Directed bench for ip_ccm3_prog. A second instance with YCBCR_POS=1 receives
// the same pixels with c1/c2 shifted into offset binary, so both instances must
// produce identical results. Inputs change right after a falling edge and
// outputs are sampled at falling edges.
`timescale 1ns/1ps

module tb_ip_ccm3_prog;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  ip_ccm3_prog_if #(.CIW(12), .COW(12)) bus ();
  ip_ccm3_prog_if #(.CIW(12), .COW(12)) bus_pos ();

`ifdef IP_CCM3_SAT_CNT_EN
  logic [15:0] sat_cnt;
  logic [15:0] sat_cnt_pos;
`endif

  ip_ccm3_prog dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef IP_CCM3_SAT_CNT_EN
    .o_sat_cnt (sat_cnt),
`endif
    .bus       (bus)
  );

  ip_ccm3_prog #(.YCBCR_POS(1'b1)) dut_pos (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef IP_CCM3_SAT_CNT_EN
    .o_sat_cnt (sat_cnt_pos),
`endif
    .bus       (bus_pos)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic setCfg(input logic wr, input int addr, input int data, input logic commit);
    bus.i_cfg_wr         = wr;
    bus.i_cfg_addr       = 4'(addr);
    bus.i_cfg_data       = 16'(data);
    bus.i_cfg_commit     = commit;
    bus_pos.i_cfg_wr     = wr;
    bus_pos.i_cfg_addr   = 4'(addr);
    bus_pos.i_cfg_data   = 16'(data);
    bus_pos.i_cfg_commit = commit;
  endtask

  // Present one pixel for one clock; coefficient strobes last that clock only.
  task automatic applyStimulus(input int c0, input int c1, input int c2,
                               input logic hs, input logic hr, input logic he);
    bus.i_data_c0         = 12'(c0);
    bus.i_data_c1_sgn     = 13'(c1);
    bus.i_data_c2_sgn     = 13'(c2);
    bus_pos.i_data_c0     = 12'(c0);
    bus_pos.i_data_c1_sgn = 13'(c1 + 2048);
    bus_pos.i_data_c2_sgn = 13'(c2 + 2048);
    bus.i_hstr = hs;  bus.i_href = hr;  bus.i_hend = he;
    bus_pos.i_hstr = hs;  bus_pos.i_href = hr;  bus_pos.i_hend = he;
    @(negedge clk);
    setCfg(1'b0, 0, 0, 1'b0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkData(input string tag, input int e0, input int e1, input int e2);
    checkOutput({tag, "_d0"}, 32'(bus.o_data_0), 32'(e0));
    checkOutput({tag, "_d1"}, 32'(bus.o_data_1), 32'(e1));
    checkOutput({tag, "_d2"}, 32'(bus.o_data_2), 32'(e2));
  endtask

  initial begin
    setCfg(1'b0, 0, 0, 1'b0);
    bus.i_data_c0 = '0;  bus.i_data_c1_sgn = '0;  bus.i_data_c2_sgn = '0;
    bus.i_hstr = 1'b0;  bus.i_href = 1'b0;  bus.i_hend = 1'b0;
    bus_pos.i_data_c0 = '0;  bus_pos.i_data_c1_sgn = 13'd2048;  bus_pos.i_data_c2_sgn = 13'd2048;
    bus_pos.i_hstr = 1'b0;  bus_pos.i_href = 1'b0;  bus_pos.i_hend = 1'b0;

    repeat (2) @(negedge clk);
    checkData("reset", 0, 0, 0);
    checkOutput("reset_href", 32'(bus.o_href), 0);
    checkOutput("reset_pend", 32'(bus.o_cfg_pend), 0);
    rst_n = 1'b1;
    blank(1);

    // Defaults, neutral chroma: every row has m_k0 = 1.0 so the result is c0.
    applyStimulus(1600, 0, 0, 1'b1, 1'b1, 1'b1);
    blank(2);
    checkOutput("early_href", 32'(bus.o_href), 0);
    blank(1);
    checkData("grey", 1600, 1600, 1600);
    checkOutput("grey_hstr", 32'(bus.o_hstr), 1);
    checkOutput("grey_href", 32'(bus.o_href), 1);
    checkOutput("grey_hend", 32'(bus.o_hend), 1);
    checkOutput("grey_pos_d1", 32'(bus_pos.o_data_1), 1600);
    blank(1);
    checkOutput("after_href", 32'(bus.o_href), 0);

    // Clipping: row0 overflows, then rows 1/2 go negative.
    applyStimulus(4095, 0, 1600, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1600, 1'b0, 1'b1, 1'b0);
    blank(2);
    checkData("clip_hi", 4095, 3791, 3971);
    checkOutput("clip_hi_pos_d0", 32'(bus_pos.o_data_0), 4095);
    blank(1);
    checkData("clip_lo", 313, 0, 0);
    checkOutput("clip_lo_pos_d1", 32'(bus_pos.o_data_1), 0);
    blank(2);

    // Identity loaded and committed mid-line: this line stays on defaults.
    applyStimulus(800, 320, 320, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      setCfg(1'b1, i, (i % 4 == 0) ? 4096 : 0, i == 8);
      applyStimulus(800, 320, 320, 1'b0, 1'b1, 1'b0);
    end
    setCfg(1'b1, 9, 16'h7FFF, 1'b0);
    applyStimulus(800, 320, 320, 1'b0, 1'b1, 1'b0);
    checkOutput("pend_midline", 32'(bus.o_cfg_pend), 1);
    checkData("midline", 833, 725, 1103);
    applyStimulus(800, 320, 320, 1'b0, 1'b1, 1'b1);
    checkOutput("pend_lineend", 32'(bus.o_cfg_pend), 1);
    blank(1);
    checkOutput("pend_blank", 32'(bus.o_cfg_pend), 0);
    blank(2);
    checkData("old_set_hend", 833, 725, 1103);
    checkOutput("old_set_hend_flag", 32'(bus.o_hend), 1);
    checkOutput("old_set_pos_d2", 32'(bus_pos.o_data_2), 1103);
    applyStimulus(800, 320, 320, 1'b1, 1'b1, 1'b1);
    blank(3);
    checkData("identity", 800, 320, 320);
    checkOutput("identity_pos_d0", 32'(bus_pos.o_data_0), 800);

    // Reset mid-line with a commit pending.
    setCfg(1'b0, 0, 0, 1'b1);
    applyStimulus(800, 320, 320, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(800, 320, 320, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_href", 32'(bus.o_href), 1);
    checkOutput("pre_rst_pend", 32'(bus.o_cfg_pend), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_d0", 32'(bus.o_data_0), 0);
    checkOutput("rst_href", 32'(bus.o_href), 0);
    checkOutput("rst_pend", 32'(bus.o_cfg_pend), 0);
    blank(2);
    rst_n = 1'b1;
    applyStimulus(800, 320, 320, 1'b1, 1'b1, 1'b1);
    blank(3);
    checkData("rst_defaults", 833, 725, 1103);
    blank(2);

`ifdef IP_CCM3_SAT_CNT_EN
    // Ten pixels, clipping at 1, 6 and the hend pixel 9.
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 6 || i == 9) applyStimulus(4095, 0, 1600, i == 0, 1'b1, i == 9);
      else                            applyStimulus(1600, 0, 0,    i == 0, 1'b1, i == 9);
    end
    blank(3);
    checkOutput("sat_hend_flag", 32'(bus.o_hend), 1);
    checkOutput("sat_line1", 32'(sat_cnt), 3);
    checkOutput("sat_line1_pos", 32'(sat_cnt_pos), 3);
    // Next line: only the hstr pixel clips.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) applyStimulus(4095, 0, 1600, 1'b1, 1'b1, 1'b0);
      else        applyStimulus(1600, 0, 0,    1'b0, 1'b1, i == 9);
    end
    blank(3);
    checkOutput("sat_line2", 32'(sat_cnt), 1);
    blank(2);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ip_ccm3_prog.md
# ip_ccm3_prog

Programmable 3x3 color-matrix converter, the parametrised successor of the fixed YCbCr-to-LMS stage in the color_convert path. It takes one unsigned luma-type channel and two signed chroma-type channels, multiplies by a runtime-loadable S3.12 matrix, then rounds, shifts and clips to unsigned outputs. New coefficients are loaded through a shadow/commit port and take effect only in horizontal blanking, so a line is never converted with mixed coefficients. Default coefficients reproduce the existing YCbCr-to-LMS conversion.

## Interface
Parameters:
- CIIW, 8, input integer width (sign included for c1/c2)
- CIPW, 4, input fraction width
- COIW, 8, output integer width
- COPW, 4, output fraction width
- CIW, CIIW+CIPW, input width (derived)
- COW, COIW+COPW, output width (derived)
- YCBCR_POS, 0, 1 = c1/c2 arrive offset-binary and are normalised by subtracting 2^(CIW-1)

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_data_c0  in  CIW  unsigned channel 0 (Y)
- i_data_c1_sgn  in  CIW+1  signed channel 1 (Cb)
- i_data_c2_sgn  in  CIW+1  signed channel 2 (Cr)
- i_hstr / i_href / i_hend  in  1  line start / valid / line end
- i_cfg_wr  in  1  shadow coefficient write strobe
- i_cfg_addr  in  4  coefficient index 0..8, row-major m00..m22; 9..15 ignored
- i_cfg_data  in  16  signed S3.12 coefficient
- i_cfg_commit  in  1  request shadow-to-active transfer
- o_data_0 / o_data_1 / o_data_2  out  COW  clipped results, rows 0/1/2
- o_hstr / o_href / o_hend  out  1  sync delayed by 4 cycles
- o_cfg_pend  out  1  commit requested, not yet applied
- o_sat_cnt  out  16  clipped-pixel count of last line (only with IP_CCM3_SAT_CNT_EN)

## Operation
- Reset: all outputs 0. Shadow and active matrices are set to the defaults: row0 {4096,-384,802}, row1 {4096,-181,-777}, row2 {4096,4192,-318}. Pending flag is cleared. Pipeline registers are zeroed.
- Normalisation: n1 = c1 − (YCBCR_POS ? 2^(CIW-1) : 0), computed at CIW+2 bits signed. n2 uses the same rule. c0 is zero-extended.
- Row k: acc = m_k0·c0 + m_k1·n1 + m_k2·n2 + 2^(SH−1), with SH = 12+CIPW−COPW. Products use the full (CIW+2)+16 bits. The accumulator adds 2 guard bits. There is no intermediate truncation.
- Result = acc >>> SH (arithmetic). If result < 0, output 0. If result > 2^COW−1, output 2^COW−1. Otherwise output the result.
- Config write: on i_cfg_wr with addr ≤ 8, the shadow[addr] register takes i_cfg_data at that edge. Writes with addr > 8 have no effect.
- Commit: i_cfg_commit sets pend. A write and a commit in the same cycle: the write is included in the commit. A commit while pend is already set has no extra effect.
- Apply: on any edge where pend=1 and i_href=0 and i_hstr=0, active <= shadow and pend clears. The transfer never happens while i_href is high.
- Coefficients are used only in stage 2. A pixel sampled before the apply edge uses the old set; a pixel sampled after uses the new set.
- Shadow writes after a commit but before the apply edge are included in the transfer.
- The datapath is free-running. Data registers update every cycle regardless of href.

## Timing
- Latency is 4 cycles from input edge to output register:
  - S1: normalise and register inputs.
  - S2: three-per-row products.
  - S3: sum, round, shift.
  - S4: clip into o_data_*.
- o_hstr/o_href/o_hend are a 4-deep shift of the inputs and stay aligned with data.
- o_cfg_pend rises the cycle after the commit edge. It falls the cycle after the apply edge.
- The earliest apply is the edge after the commit edge, provided blanking holds.
- Reset asserted mid-line: all state returns to reset values immediately. Any partial line is lost and no sync pulses are emitted.
- Throughput is one pixel per clock. There is no backpressure.

## Configuration
- Macro `IP_CCM3_SAT_CNT_EN`.
- Defined:
  - A 16-bit counter increments on each S4 pixel with delayed href=1 where any channel clipped. The counter saturates at 0xFFFF.
  - On the S4 cycle with delayed hend=1, o_sat_cnt <= count including that pixel, and the counter clears.
  - On delayed hstr, the counter restarts from that pixel.
  - o_sat_cnt resets to 0.
- Undefined: the o_sat_cnt port and counter logic are absent. All other behaviour is identical.

## Test plan
- Defaults, YCBCR_POS=0: c0=1600 (100.0), c1=c2=0 with hstr/href/hend → o_data_0/1/2=1600 exactly 4 cycles later, sync aligned.
- Clip: c0=4095, c2=+1600 → o_data_0=4095 (overflow). c0=0, c2=+1600 → o_data_1=0 (underflow).
- Update: write the identity matrix (4096 diagonal) and commit mid-line → rest of line still uses defaults and o_cfg_pend=1. After the first blanking cycle o_cfg_pend=0. Next line with c0=800, c1=c2=320 → outputs 800/320/320.
- YCBCR_POS=1: c1=c2=2048, c0=1600 → all outputs 1600.
- Macro on: 10-pixel line with 3 clipping pixels, including the hend pixel → o_sat_cnt=3 after the hend output. Next line counts from 0.
- Assert rst_n low mid-line → outputs, sync and pend drop to 0 at once. Coefficients revert to defaults, checked with the first scenario.
